// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: byte-stream program loader for the PicoBlaze program memory.
// Frame: HDR_BYTE, len[15:8], len[7:0], (len+1) words of BPW bytes MSB first,
// plus a trailing mod-256 checksum byte when LOADER_CSUM_EN is defined.
// Ports: clk/rst_n (async active-low); rx_valid/rx_data/rx_ready byte input;
// cpu_rst held high while loading; mem_port_wr/addr/data memory write port
// (memory write clock is clk); busy, done pulse, sticky error status.
module cpu_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int INSTR_W = 18,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               cpu_rst,
  output logic               mem_port_wr,
  output logic [ADDR_W-1:0]  mem_port_addr,
  output logic [INSTR_W-1:0] mem_port_data,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int BPW = (INSTR_W + 7) / 8;
  localparam int AW = BPW * 8;
  localparam int BCW = $clog2(BPW + 1);
  localparam int unsigned DEPTH = 32'(1) << ADDR_W;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE,
`ifdef LOADER_CSUM_EN
    CSUM,
`endif
    DONE, ERR} st_t;
  st_t st;
  logic [15:0] len;
  logic [ADDR_W-1:0] cnt;
  logic [BCW-1:0] bc;
  logic [AW-1:0] shreg;
  logic [AW-1:0] nxt;
  logic hs;
  assign hs = rx_valid && rx_ready;
  assign nxt = AW'({shreg, rx_data});
`ifdef LOADER_CSUM_EN
  logic [7:0] sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (hs) sum <= (st == LEN_HI || st == LEN_LO || st == DATA) ? sum + rx_data :
                        (st == CSUM) ? sum : 8'd0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      len <= '0;
      cnt <= '0;
      bc <= '0;
      shreg <= '0;
      rx_ready <= 1'b0;
      cpu_rst <= 1'b0;
      mem_port_wr <= 1'b0;
      mem_port_addr <= '0;
      mem_port_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      mem_port_wr <= 1'b0;
      done <= 1'b0;
      case (st)
        // DONE and ERR last one cycle and already accept bytes as IDLE would
        IDLE, DONE, ERR: begin
          st <= IDLE;
          if (hs && rx_data == HDR_BYTE) begin
            st <= LEN_HI;
            cpu_rst <= 1'b1;
            busy <= 1'b1;
            error <= 1'b0;
            cnt <= '0;
            bc <= '0;
          end
        end
        LEN_HI: if (hs) begin
          len[15:8] <= rx_data;
          st <= LEN_LO;
        end
        LEN_LO: if (hs) begin
          len[7:0] <= rx_data;
          if (32'({len[15:8], rx_data}) >= DEPTH) begin
            st <= ERR;
            error <= 1'b1;
            busy <= 1'b0;
          end else st <= DATA;
        end
        DATA: if (hs) begin
          shreg <= nxt;
          bc <= (bc == BCW'(BPW - 1)) ? '0 : bc + 1'b1;
          if (bc == BCW'(BPW - 1)) begin
            st <= WRITE;
            rx_ready <= 1'b0;
            mem_port_wr <= 1'b1;
            mem_port_addr <= cnt;
            mem_port_data <= INSTR_W'(nxt);
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (32'(cnt) == 32'(len)) begin
`ifdef LOADER_CSUM_EN
            st <= CSUM;
`else
            st <= DONE;
            done <= 1'b1;
            cpu_rst <= 1'b0;
            busy <= 1'b0;
`endif
          end else st <= DATA;
        end
`ifdef LOADER_CSUM_EN
        CSUM: if (hs) begin
          busy <= 1'b0;
          if (rx_data == sum) begin
            st <= DONE;
            done <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            st <= ERR;
            error <= 1'b1;
          end
        end
`endif
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_prog_loader.sv
module tb_cpu_prog_loader;
  logic clk = 1'b0;
  logic rst_n, rx_valid, rx_ready, cpu_rst, mem_port_wr, busy, done, error;
  logic [7:0] rx_data;
  logic [9:0] mem_port_addr;
  logic [17:0] mem_port_data;
  int checks = 0, errors = 0, cyc = 0, ndone = 0, wcyc = 0, dcyc = 0, rdy_bad = 0;
  bit arm = 1'b0;
  logic [9:0] wa[$];
  logic [17:0] wd[$];

  typedef struct {
    logic v;
    logic [7:0] d;
    logic rdy, cpu, wr, bsy, dn, err;
    logic [9:0] addr;
    logic [17:0] data;
  } vec_t;
  vec_t tbl[$];

  cpu_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .cpu_rst(cpu_rst), .mem_port_wr(mem_port_wr), .mem_port_addr(mem_port_addr),
    .mem_port_data(mem_port_data), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mem_port_wr) begin
      wa.push_back(mem_port_addr);
      wd.push_back(mem_port_data);
      wcyc = cyc;
    end
    if (done) begin
      ndone++;
      dcyc = cyc;
    end
    if (arm && !rx_ready && !mem_port_wr) rdy_bad++;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic cpu,
                     input logic wr, input logic bsy, input logic dn, input logic err,
                     input logic [9:0] addr, input logic [17:0] data);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.cpu = cpu; t.wr = wr; t.bsy = bsy;
    t.dn = dn; t.err = err; t.addr = addr; t.data = data;
    tbl.push_back(t);
  endtask

  // Called at a negedge; returns at the negedge after the byte's handshake edge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rx_ready got 0 expected 1 for byte %0h", b);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    add(0, 8'h00, 1, 0, 0, 0, 0, 0, 10'd0, 18'h0);
    add(1, 8'hA5, 1, 1, 0, 1, 0, 0, 10'd0, 18'h0);
    add(1, 8'h00, 1, 1, 0, 1, 0, 0, 10'd0, 18'h0);
    add(1, 8'h01, 1, 1, 0, 1, 0, 0, 10'd0, 18'h0);
    add(1, 8'h01, 1, 1, 0, 1, 0, 0, 10'd0, 18'h0);
    add(1, 8'h23, 1, 1, 0, 1, 0, 0, 10'd0, 18'h0);
    add(1, 8'h45, 0, 1, 1, 1, 0, 0, 10'd0, 18'h12345);
    add(1, 8'h03, 1, 1, 0, 1, 0, 0, 10'd0, 18'h12345);
    add(1, 8'h03, 1, 1, 0, 1, 0, 0, 10'd0, 18'h12345);
    add(1, 8'hFF, 1, 1, 0, 1, 0, 0, 10'd0, 18'h12345);
    add(1, 8'hFF, 0, 1, 1, 1, 0, 0, 10'd1, 18'h3FFFF);
`ifdef LOADER_CSUM_EN
    add(1, 8'h6B, 1, 1, 0, 1, 0, 0, 10'd1, 18'h3FFFF);
    add(1, 8'h6B, 1, 0, 0, 0, 1, 0, 10'd1, 18'h3FFFF);
`else
    add(0, 8'h00, 1, 0, 0, 0, 1, 0, 10'd1, 18'h3FFFF);
`endif
    add(0, 8'h00, 1, 0, 0, 0, 0, 0, 10'd1, 18'h3FFFF);

    repeat (3) @(negedge clk);
    chk("reset_values", {rx_ready, cpu_rst, mem_port_wr, busy, done, error, mem_port_addr, mem_port_data}, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      rx_valid = tbl[i].v;
      rx_data = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {rx_ready, cpu_rst, mem_port_wr, busy, done, error, mem_port_addr, mem_port_data},
          {tbl[i].rdy, tbl[i].cpu, tbl[i].wr, tbl[i].bsy, tbl[i].dn, tbl[i].err, tbl[i].addr, tbl[i].data});
    end
    @(negedge clk);
    rx_valid = 1'b0;
    wa.delete();
    wd.delete();

    send(8'hA5); send(8'h04); send(8'h00);
    rx_valid = 1'b0;
    chk("len_err_now", {error, busy, cpu_rst}, 3'b101);
    repeat (3) @(negedge clk);
    chk("len_err_nowrite", wa.size(), 0);
    chk("len_err_sticky", {error, busy, cpu_rst}, 3'b101);

    arm = 1'b1;
    ndone = 0;
    send(8'h11); send(8'h22);
    chk("garbage_dropped", {busy, error}, 2'b01);
    send(8'hA5);
    chk("hdr_clears_err", {busy, error, cpu_rst}, 3'b101);
    send(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    send(8'h00); send(8'h01);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h23); send(8'h45);
`ifdef LOADER_CSUM_EN
    send(8'h69);
`endif
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    arm = 1'b0;
    chk("one_word_count", wa.size(), 1);
    chk("one_word_addr", wa[0], 10'd0);
    chk("one_word_data", wd[0], 18'h12345);
    chk("rdy_low_only_write", rdy_bad, 0);
    chk("one_word_done", ndone, 1);
    chk("one_word_release", {cpu_rst, busy, error}, 3'b000);

    wa.delete();
    wd.delete();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h01); send(8'h23);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {rx_ready, cpu_rst, mem_port_wr, busy, done, error, mem_port_addr, mem_port_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hA5); send(8'h00); send(8'h00); send(8'hAB); send(8'hCD); send(8'hEF);
`ifdef LOADER_CSUM_EN
    send(8'h67);
`endif
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_count", wa.size(), 1);
    chk("post_reset_addr", wa[0], 10'd0);
    chk("post_reset_data", wd[0], 18'h3CDEF);

    wa.delete();
    wd.delete();
`ifdef LOADER_CSUM_EN
    send(8'hA5); send(8'h00); send(8'h01); send(8'h01); send(8'h23); send(8'h45);
    send(8'h03); send(8'hFF); send(8'hFF); send(8'h6C);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bad_csum_writes", wa.size(), 2);
    chk("bad_csum_status", {error, cpu_rst, busy}, 3'b110);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h23); send(8'h45); send(8'h69);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("recover_status", {error, cpu_rst, busy}, 3'b000);
`else
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h23); send(8'h45);
    send(8'hA5);
    rx_valid = 1'b0;
    chk("nocsum_write", {wa.size() == 1, wd[0]}, {1'b1, 18'h12345});
    chk("nocsum_done_latency", dcyc - wcyc, 1);
    chk("next_byte_is_header", {busy, cpu_rst, error}, 3'b110);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation got stuck expected completion");
    $fatal(1);
  end
endmodule
